// File: rtl/go_launcher_pkg.sv
// Shared definitions for the go_launcher block: state encoding and default sizing.
package go_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } launch_state_t;

  localparam int MAX_PENDING_DEF    = 4;
  localparam int TIMEOUT_CYCLES_DEF = 32;
  localparam int RUNS_W_DEF         = 8;
  localparam int PEND_W             = 4;

endpackage

// File: rtl/go_launcher_sat_updown_counter.sv
// Saturating up/down counter that holds queued launch requests and flags any
// request dropped while full.
module sat_updown_counter
  import go_launcher_pkg::*;
#(
  parameter int W   = PEND_W,
  parameter int MAX = MAX_PENDING_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_overflow
);

  logic [W-1:0] r_count;
  logic         r_overflow;

  // A simultaneous increment and decrement cancel; a new overflow beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_clr) begin
        r_overflow <= 1'b0;
      end
      if (i_inc && !i_dec) begin
        if (r_count == W'(MAX)) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else if (i_dec && !i_inc && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/go_launcher.sv
// Turns start requests into one-cycle go pulses, queues requests during a run,
// tracks each run until done and flags runs that never finish.
module go_launcher
  import go_launcher_pkg::*;
#(
  parameter int MAX_PENDING    = MAX_PENDING_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int RUNS_W         = RUNS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              done,
  input  logic              err_clr,
  output logic              go,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow_err,
  output logic              timeout_err,
  output logic [RUNS_W-1:0] runs_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  launch_state_t     r_state;
  logic              r_reqQ;
  logic              r_go;
  logic              r_busy;
  logic              r_timeoutErr;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [RUNS_W-1:0] r_runsDone;

  logic              w_reqRise;
  logic              w_launch;
  logic              w_timeoutHit;
  logic [PEND_W-1:0] w_pending;
  logic              w_overflowErr;

  assign w_reqRise    = req & ~r_reqQ;
  assign w_launch     = (r_state == IDLE) && ((w_pending != '0) || w_reqRise);
  assign w_timeoutHit = (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  sat_updown_counter #(
    .W   (PEND_W),
    .MAX (MAX_PENDING)
  ) u_pending (
    .clk        (clk),
    .rst_n      (rst),
    .i_inc      (w_reqRise),
    .i_dec      (w_launch),
    .i_clr      (err_clr),
    .o_count    (w_pending),
    .o_overflow (w_overflowErr)
  );

  // go and busy are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_reqQ       <= 1'b0;
      r_go         <= 1'b0;
      r_busy       <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_waitCnt    <= '0;
      r_runsDone   <= '0;
    end else begin
      r_reqQ <= req;
      if (err_clr) begin
        r_timeoutErr <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_go   <= w_launch;
          r_busy <= w_launch;
          if (w_launch) begin
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_state   <= WAIT;
          r_go      <= 1'b0;
          r_busy    <= 1'b1;
          r_waitCnt <= '0;
        end
        WAIT: begin
          r_go      <= 1'b0;
          r_waitCnt <= r_waitCnt + 1'b1;
          if (done) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_runsDone <= r_runsDone + 1'b1;
          end else if (w_timeoutHit) begin
            // The run is abandoned; queued requests still launch afterwards.
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_go    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign go           = r_go;
  assign busy         = r_busy;
  assign pending      = w_pending;
  assign overflow_err = w_overflowErr;
  assign timeout_err  = r_timeoutErr;
  assign runs_done    = r_runsDone;

endmodule

// File: tb/tb_go_launcher.sv
// Self-checking bench for go_launcher: expected go cycles are queued when
// requests are driven and compared as go pulses appear.
module tb_go_launcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       done;
  logic       err_clr;
  logic       go;
  logic       busy;
  logic [3:0] pending;
  logic       overflow_err;
  logic       timeout_err;
  logic [7:0] runs_done;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   doneAt = -1;
  logic doneEnable = 1'b1;
  logic modelDone = 1'b0;
  logic manualDone = 1'b0;
  int   expGo[$];

  assign done = modelDone | manualDone;

  go_launcher #(
    .MAX_PENDING    (4),
    .TIMEOUT_CYCLES (32),
    .RUNS_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .err_clr      (err_clr),
    .go           (go),
    .busy         (busy),
    .pending      (pending),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .runs_done    (runs_done)
  );

  always #5 clk = ~clk;

  // Counter FSM stand-in: done arrives 16 cycles after the go it saw.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    modelDone = doneEnable && (cyc == doneAt);
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard consumer: every go pulse must match the next queued cycle.
  always @(negedge clk) begin
    if (rst && go) begin
      checkOutput("go_expected", int'(expGo.size() != 0), 1);
      if (expGo.size() != 0) begin
        checkOutput("go_cycle", cyc, expGo.pop_front());
      end
      doneAt = cyc + 16;
    end
  end

  task automatic gotoCycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int t, input bit pushGo, input int goCycle);
    gotoCycle(t);
    req = 1'b1;
    if (pushGo) expGo.push_back(goCycle);
    gotoCycle(t + 1);
    req = 1'b0;
  endtask

  task automatic sampleAt(input int t);
    gotoCycle(t);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req = 1'b0;
    err_clr = 1'b0;

    @(negedge clk);
    checkOutput("rst_go", int'(go), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_pending", int'(pending), 0);
    checkOutput("rst_runs", int'(runs_done), 0);
    gotoCycle(2);
    rst = 1'b1;
    sampleAt(3);
    checkOutput("idle_busy", int'(busy), 0);

    // Single request held high for ten cycles
    gotoCycle(5);
    req = 1'b1;
    expGo.push_back(6);
    sampleAt(10);
    checkOutput("single_busy", int'(busy), 1);
    gotoCycle(15);
    req = 1'b0;
    sampleAt(25);
    checkOutput("single_runs", int'(runs_done), 1);
    checkOutput("single_idle", int'(busy), 0);
    checkOutput("single_pending", int'(pending), 0);

    // Three requests queued during a run, each launched 2 cycles after done
    applyStimulus(30, 1, 31);
    applyStimulus(34, 1, 49);
    applyStimulus(36, 1, 67);
    applyStimulus(38, 1, 85);
    sampleAt(40);
    checkOutput("queue_pending3", int'(pending), 3);
    sampleAt(50);
    checkOutput("queue_pending2", int'(pending), 2);
    sampleAt(68);
    checkOutput("queue_pending1", int'(pending), 1);
    sampleAt(86);
    checkOutput("queue_pending0", int'(pending), 0);
    sampleAt(104);
    checkOutput("queue_runs", int'(runs_done), 5);

    // Six requests while busy: four queue, two overflow
    applyStimulus(110, 1, 111);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(113 + 2 * i, (i < 4), 129 + 18 * i);
    end
    sampleAt(124);
    checkOutput("ovf_pending", int'(pending), 4);
    checkOutput("ovf_flag", int'(overflow_err), 1);
    gotoCycle(125);
    err_clr = 1'b1;
    gotoCycle(126);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared", int'(overflow_err), 0);
    checkOutput("ovf_pending_kept", int'(pending), 4);
    sampleAt(202);
    checkOutput("ovf_runs", int'(runs_done), 10);
    checkOutput("ovf_drained", int'(pending), 0);

    // Timeout with err_clr on the timeout cycle, then relaunch of queued work
    gotoCycle(205);
    doneEnable = 1'b0;
    applyStimulus(210, 1, 211);
    applyStimulus(215, 1, 245);
    gotoCycle(243);
    err_clr = 1'b1;
    @(negedge clk);
    checkOutput("to_busy_last", int'(busy), 1);
    checkOutput("to_flag_early", int'(timeout_err), 0);
    gotoCycle(244);
    err_clr = 1'b0;
    applyStimulus(244, 1, 263);
    @(negedge clk);
    checkOutput("to_flag_set", int'(timeout_err), 1);
    checkOutput("to_runs_same", int'(runs_done), 10);
    checkOutput("to_pending_kept", int'(pending), 1);
    gotoCycle(250);
    doneEnable = 1'b1;
    sampleAt(282);
    checkOutput("to_runs_after", int'(runs_done), 12);
    checkOutput("to_sticky", int'(timeout_err), 1);
    gotoCycle(285);
    err_clr = 1'b1;
    gotoCycle(286);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("to_cleared", int'(timeout_err), 0);

    // Stray done while idle
    gotoCycle(290);
    manualDone = 1'b1;
    gotoCycle(291);
    manualDone = 1'b0;
    sampleAt(292);
    checkOutput("idle_done_runs", int'(runs_done), 12);

    // Asynchronous reset mid-WAIT with pending work and a timeout flagged
    gotoCycle(295);
    doneEnable = 1'b0;
    applyStimulus(300, 1, 301);
    applyStimulus(303, 1, 335);
    applyStimulus(305, 0, 0);
    applyStimulus(337, 0, 0);
    sampleAt(340);
    checkOutput("pre_rst_pending", int'(pending), 2);
    checkOutput("pre_rst_timeout", int'(timeout_err), 1);
    checkOutput("pre_rst_busy", int'(busy), 1);
    gotoCycle(341);
    #2;
    rst = 1'b0;
    doneAt = -1;
    #1;
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_pending", int'(pending), 0);
    checkOutput("arst_timeout", int'(timeout_err), 0);
    checkOutput("arst_overflow", int'(overflow_err), 0);
    checkOutput("arst_runs", int'(runs_done), 0);
    checkOutput("arst_go", int'(go), 0);
    gotoCycle(344);
    rst = 1'b1;
    doneEnable = 1'b1;
    sampleAt(345);
    checkOutput("post_rst_busy", int'(busy), 0);
    applyStimulus(350, 1, 351);
    sampleAt(370);
    checkOutput("post_rst_runs", int'(runs_done), 1);
    checkOutput("all_go_seen", expGo.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
